alu_issue_ctrl: RTL

- Upstream issue and writeback stage for alu_8_bit.
- Accepts operand/opcode commands through a valid/ready interface and buffers them in a small FIFO.
- Drives alu_8_bit one command at a time, waits the ALU's fixed latency, and captures alu_out/carry_out.
- Returns each result on a valid/ready response port; illegal opcodes are rejected without issuing to the ALU.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_issue_ctrl_if.sv | 37 +++
 rtl/alu_cmd_fifo.sv | 70 +++++++
 rtl/alu_issue_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared widths, opcodes, FSM states and command record for the
//            alu_8_bit issue controller.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h7;
    localparam logic [OP_W-1:0] OP_INC  = 4'h8;
    localparam logic [OP_W-1:0] OP_DEC  = 4'h9;
    localparam logic [OP_W-1:0] OP_PASS = 4'hA;
    localparam logic [OP_W-1:0] OP_MAX  = OP_PASS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Purpose  : Command and response valid/ready channels of the issue controller.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [OP_W-1:0]   cmd_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry;
    logic              rsp_err;

    // Producer of commands / consumer of responses
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
    );

    // The issue controller itself
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_fifo
// Purpose  : Show-ahead command FIFO; head entry is visible while not empty.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire alu_cmd_t                 i_data,
    input  wire logic                     i_pop,
    output alu_cmd_t                      o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_fcnt_w = $clog2(DEPTH) + 1;

    alu_cmd_t              r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_fcnt_w-1:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == c_fcnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage carries no reset; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_fcnt_w'(1);
                2'b01:   r_count <= r_count - c_fcnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Buffers ALU commands, issues them one at a time to alu_8_bit,
//            waits its fixed latency and returns results in command order.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int              DATA_W  = alu_pkg::DATA_W,
    parameter int              OP_W    = alu_pkg::OP_W,
    parameter int              DEPTH   = 4,
    parameter int              ALU_LAT = 1,
    parameter logic [OP_W-1:0] OP_MAX  = alu_pkg::OP_MAX
) (
    input  wire logic              clk,
    input  wire logic              rst,
    alu_issue_ctrl_if.slave        bus,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [OP_W-1:0]        alu_op,
    input  wire logic [DATA_W-1:0] alu_res,
    input  wire logic              alu_cy,
    output logic                   busy
);

    localparam int c_lat_w  = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam int c_fcnt_w = $clog2(DEPTH) + 1;

    state_t                r_state;
    logic [c_lat_w-1:0]    r_cnt;
    logic [DATA_W-1:0]     r_alu_a;
    logic [DATA_W-1:0]     r_alu_b;
    logic [OP_W-1:0]       r_alu_op;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_data;
    logic                  r_rsp_carry;
    logic                  r_rsp_err;

    alu_cmd_t              w_cmd_in;
    alu_cmd_t              w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_fcnt_w-1:0]   w_fifo_count;
    logic                  w_pop;

    assign w_cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
    assign w_pop    = (r_state == IDLE) && !w_fifo_empty;

    alu_cmd_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus.cmd_ready = !w_fifo_full;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_carry = r_rsp_carry;
    assign bus.rsp_err   = r_rsp_err;

    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;
    assign busy   = (r_state != IDLE) || (w_fifo_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        if (w_head.op <= OP_MAX) begin
                            r_alu_a  <= w_head.a;
                            r_alu_b  <= w_head.b;
                            r_alu_op <= w_head.op;
                            r_cnt    <= c_lat_w'(ALU_LAT);
                            r_state  <= WAIT;
                        end else begin
                            // Rejected without touching the ALU inputs
                            r_rsp_data  <= '0;
                            r_rsp_carry <= 1'b0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_lat_w'(1);
                    end else begin
                        r_rsp_data  <= alu_res;
                        r_rsp_carry <= alu_cy;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
